// File: rtl/cpu_io_router.sv
// cpu_io_router: synchronises Z80 I/O strobes, decodes A[7:2] per channel and routes requests/read data
module cpu_io_router #(
    parameter int                    CHANNELS    = 3,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [CHANNELS*6-1:0] BASE        = {6'h3F, 6'h24, 6'h26},
    parameter logic [CHANNELS*6-1:0] MASK        = {3{6'h3F}},
    parameter int                    TIMEOUT     = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:2]              A,
    input  logic                    rd_iorq_n,
    input  logic                    wr_iorq_n,
    input  logic [7:0]              cd_in,
    output logic [7:0]              cd_out,
    output logic                    cd_oe,
    output logic                    cs_n,
    output logic [CHANNELS-1:0]     io_req,
    output logic                    io_wr,
    output logic [1:0]              io_addr,
    output logic [7:0]              io_wdata,
    input  logic [CHANNELS*8-1:0]   io_rdata,
    input  logic [CHANNELS-1:0]     io_ack,
    output logic                    timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_HOLD, S_IGNORE} state_t;
    localparam int         CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_rd_sync, r_wr_sync;
    logic                   r_rd_prev, r_wr_prev;
    logic [CW-1:0]          r_ch, w_sel;
    logic [7:0]             r_cnt;
    logic                   w_rd, w_wr, w_det, w_hit, w_start, w_ack, w_tmo, w_strb;

    assign w_rd   = r_rd_sync[SYNC_STAGES-1];
    assign w_wr   = r_wr_sync[SYNC_STAGES-1];
    assign w_det  = (w_rd & ~r_rd_prev) | (w_wr & ~r_wr_prev);
    assign w_ack  = io_ack[r_ch];
    assign w_tmo  = r_cnt == TO_LAST;
    assign w_strb = io_wr ? w_wr : w_rd;

    // Strobe synchronisers (stored active-high); left unreset so they track the pins through reset
    always_ff @(posedge clk) begin
        r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], ~rd_iorq_n};
        r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], ~wr_iorq_n};
    end

    // Previous-strobe registers reset to asserted so a strobe held through reset is not seen as new
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_prev <= 1'b1;
            r_wr_prev <= 1'b1;
        end else begin
            r_rd_prev <= w_rd;
            r_wr_prev <= w_wr;
        end
    end

    // Address decode: scanning downwards leaves the lowest matching channel selected
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (((A ^ BASE[6*k +: 6]) & MASK[6*k +: 6]) == 6'd0) begin
                w_hit = 1'b1;
                w_sel = CW'(k);
            end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and state-decoded bus outputs
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        cd_oe   = 1'b0;
        cs_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_start = w_det && (w_rd ^ w_wr) && w_hit;
                w_next  = w_start ? S_WAIT_ACK : w_det ? S_IGNORE : S_IDLE;
            end
            S_WAIT_ACK: begin
                cs_n   = 1'b0;
                w_next = (w_ack || w_tmo) ? S_HOLD : S_WAIT_ACK;
            end
            S_HOLD: begin
                cs_n   = 1'b0;
                cd_oe  = ~io_wr;
                w_next = w_strb ? S_HOLD : S_IDLE;
            end
            default: w_next = (w_rd || w_wr) ? S_IGNORE : S_IDLE;
        endcase
    end

    // Access latching, single-cycle request, ack capture and timeout response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch        <= '0;
            r_cnt       <= 8'd0;
            io_req      <= '0;
            io_wr       <= 1'b0;
            io_addr     <= 2'd0;
            io_wdata    <= 8'd0;
            cd_out      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            io_req <= '0;
            if (w_start) begin
                r_ch     <= w_sel;
                r_cnt    <= 8'd0;
                io_req   <= CHANNELS'(1) << w_sel;
                io_wr    <= w_wr;
                io_addr  <= A[3:2];
                io_wdata <= cd_in;
            end else if (r_state == S_WAIT_ACK) begin
                r_cnt <= r_cnt + 8'd1;
                if (w_ack) begin
                    if (!io_wr) cd_out <= io_rdata[r_ch*8 +: 8];
                end else if (w_tmo) begin
                    cd_out      <= 8'hFF;
                    timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_io_router.sv
// tb_cpu_io_router: scoreboard bench for cpu_io_router request routing, read return, timeout and reset
module tb_cpu_io_router;
    localparam int SYNC = 2;
    localparam int TO   = 15;

    typedef struct packed {
        logic [2:0] req;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wd;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  a;
    logic        rd_iorq_n, wr_iorq_n;
    logic [7:0]  cd_in, cd_out, io_wdata;
    logic        cd_oe, cs_n, io_wr, timeout_err;
    logic [2:0]  io_req, io_ack;
    logic [1:0]  io_addr;
    logic [23:0] io_rdata;

    req_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       oe_d = 1'b0;

    cpu_io_router #(
        .CHANNELS(3),
        .SYNC_STAGES(SYNC),
        .BASE({6'h3F, 6'h24, 6'h26}),
        .MASK({6'h3F, 6'h3C, 6'h3F}),
        .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .reset(reset), .A(a), .rd_iorq_n(rd_iorq_n), .wr_iorq_n(wr_iorq_n),
        .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n), .io_req(io_req),
        .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .io_ack(io_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every request pulse and every cd_oe rise consumes one expected entry
    always @(negedge clk) begin
        req_t e;
        if (io_req != 3'b000) begin
            if (exp_q.size() == 0) chk("req_unexpected", io_req, 0);
            else begin
                e = exp_q.pop_front();
                chk("io_req", io_req, e.req);
                chk("io_wr", io_wr, e.wr);
                chk("io_addr", io_addr, e.addr);
                chk("io_wdata", io_wdata, e.wd);
            end
        end
        if (cd_oe && !oe_d) begin
            if (rd_q.size() == 0) chk("oe_unexpected", cd_oe, 0);
            else chk("cd_out", cd_out, rd_q.pop_front());
        end
        oe_d = cd_oe;
    end

    // One CPU access; ch < 0 means no channel should respond, ack_at == 0 means no ack (timeout)
    task automatic access(input logic [5:0] addr, input logic wr, input logic [7:0] wd, input int ch,
                          input int ack_at, input logic [7:0] rd, input int spur);
        int   h;
        logic mrd;
        req_t e;
        h   = (ch < 0) ? SYNC + 2 : (ack_at > 0) ? ack_at + 1 : SYNC + 1 + TO;
        mrd = (ch >= 0) && !wr;
        @(negedge clk);
        a     = addr;
        cd_in = wd;
        if (wr) wr_iorq_n = 1'b0;
        else    rd_iorq_n = 1'b0;
        if (ch >= 0) begin
            e.req  = 3'(1 << ch);
            e.wr   = wr;
            e.addr = addr[1:0];
            e.wd   = wd;
            exp_q.push_back(e);
        end
        if (mrd) rd_q.push_back(ack_at > 0 ? rd : 8'hFF);
        for (int i = 1; i <= h + 2; i++) begin
            @(negedge clk);
            if (i == SYNC + 1) chk("cs_n_active", cs_n, ch < 0);
            if (i == SYNC + 2) chk("req_single", io_req, 0);
            if (i == h - 1) chk("oe_early", cd_oe, 0);
            if (i == h) chk("oe_hold", cd_oe, mrd);
            io_ack = 3'b000;
            if (i == ack_at) begin
                io_ack[ch] = 1'b1;
                io_rdata[ch*8 +: 8] = rd;
            end
            if (spur >= 0 && i == SYNC + 1) begin
                io_ack[spur] = 1'b1;
                io_rdata[spur*8 +: 8] = 8'h77;
            end
        end
        rd_iorq_n = 1'b1;
        wr_iorq_n = 1'b1;
        for (int j = 1; j <= SYNC + 1; j++) begin
            @(negedge clk);
            if (j == SYNC) begin
                chk("oe_release_hold", cd_oe, mrd);
                chk("cs_n_hold", cs_n, ch < 0);
            end
            if (j == SYNC + 1) begin
                chk("oe_release", cd_oe, 0);
                chk("cs_n_release", cs_n, 1);
            end
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_cd_out", cd_out, 0);
        chk("rst_cd_oe", cd_oe, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_io_req", io_req, 0);
        chk("rst_io_wr", io_wr, 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_io_wdata", io_wdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
    endtask

    initial begin
        req_t e;
        reset = 1'b1; a = 6'h00; rd_iorq_n = 1'b1; wr_iorq_n = 1'b1;
        cd_in = 8'h00; io_ack = 3'b000; io_rdata = 24'h0;
        repeat (4) @(negedge clk);
        chk_reset_values();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        access(6'h26, 1'b0, 8'h00, 0, SYNC + 3, 8'h5A, -1);
        access(6'h24, 1'b1, 8'hC3, 1, SYNC + 2, 8'h00, -1);
        access(6'h10, 1'b0, 8'h00, -1, 0, 8'h00, -1);

        @(negedge clk);
        a = 6'h26; rd_iorq_n = 1'b0; wr_iorq_n = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        chk("both_cs_n", cs_n, 1);
        chk("both_oe", cd_oe, 0);
        rd_iorq_n = 1'b1; wr_iorq_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);

        chk("timeout_err_clear", timeout_err, 0);
        access(6'h3F, 1'b0, 8'h00, 2, 0, 8'h00, -1);
        chk("timeout_err_set", timeout_err, 1);

        access(6'h26, 1'b0, 8'h00, 0, SYNC + 4, 8'h11, 1);
        chk("timeout_err_sticky", timeout_err, 1);

        @(negedge clk);
        io_ack = 3'b111;
        @(negedge clk);
        io_ack = 3'b000;
        chk("idle_ack_oe", cd_oe, 0);
        chk("idle_ack_cs_n", cs_n, 1);
        chk("idle_ack_cd_out", cd_out, 8'h11);

        access(6'h25, 1'b1, 8'h3C, 1, SYNC + 1, 8'h00, -1);

        @(negedge clk);
        a = 6'h25; cd_in = 8'h99; rd_iorq_n = 1'b0;
        e.req = 3'b010; e.wr = 1'b0; e.addr = 2'b01; e.wd = 8'h99;
        exp_q.push_back(e);
        repeat (SYNC + 2) @(negedge clk);
        chk("pre_reset_cs_n", cs_n, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_values();
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_strobe_cs_n", cs_n, 1);
        chk("held_strobe_req", io_req, 0);
        rd_iorq_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);

        access(6'h3F, 1'b0, 8'h00, 2, SYNC + 2, 8'hA5, -1);
        chk("post_reset_timeout_err", timeout_err, 0);

        repeat (2) @(negedge clk);
        chk("req_queue_drained", exp_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
